// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the LCD bus arbiter: state encoding, the guard
// counter sizing helper and the default LCD data width.
package lcd_bus_pkg;

    localparam int LCD_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // Width of the guard down-counter; a guard of 0 behaves as 1, and the
    // counter is never narrower than one bit.
    function automatic int guard_cnt_w(input int guard_cyc);
        int g;
        g = (guard_cyc < 1) ? 1 : guard_cyc;
        return (g <= 1) ? 1 : $clog2(g);
    endfunction

endpackage

// File: rtl/lcd_arb_picker.sv
// Combinational winner selection for the LCD bus arbiter. Fixed mode picks
// the lowest eligible index; round-robin mode starts searching just after
// the pointer and wraps. Exactly one winner bit is set when valid is high.
module lcd_arb_picker
    import lcd_bus_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    input  logic             rr_mode,
    output logic [N_SRC-1:0] winner,
    output logic [PTR_W-1:0] winner_idx,
    output logic             valid
);

    int idx;

    // Scan candidates in priority order and keep the first eligible one.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N_SRC; k++) begin
            if (rr_mode) idx = (int'(rr_ptr) + 1 + k) % N_SRC;
            else         idx = k;
            if (!valid && eligible[idx]) begin
                valid       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Registered grant-based arbiter for the shared HD44780-style LCD bus.
// Source 0 (init sequencer) is the only eligible source until init completes.
// E is forced low on every ownership change and a guard gap separates owners.
// Handshake: a source holds src_req high for a whole transaction; while its
// src_grant bit is high its data/RS/RW/E reach the pins one cycle later;
// dropping src_req ends the transaction and E is forced low the next cycle.
module lcd_bus_arbiter
    import lcd_bus_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int DATA_W    = LCD_DATA_W,
    parameter int GUARD_CYC = 4,
    parameter int RR_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_complete_flag,
    input  logic [N_SRC-1:0]        src_req,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_rs,
    input  logic [N_SRC-1:0]        src_rw,
    input  logic [N_SRC-1:0]        src_e,
    output logic [N_SRC-1:0]        src_grant,
    output logic [DATA_W-1:0]       data,
    output logic                    RS,
    output logic                    RW,
    output logic                    E,
    output logic                    busy
);

    localparam int PTR_W = $clog2(N_SRC);
    localparam int CNT_W = guard_cnt_w(GUARD_CYC);
    localparam int GUARD_EFF = (GUARD_CYC < 1) ? 1 : GUARD_CYC;
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_EFF - 1);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_SRC - 1);

    state_t             state, state_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [N_SRC-1:0]   grant_n;
    logic [DATA_W-1:0]  data_n;
    logic               rs_n, rw_n, e_n;

    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    logic               own_req, own_rs, own_rw, own_e;
    logic [DATA_W-1:0]  own_data;
    logic               own_exit;

    assign eligible = init_complete_flag ? src_req
                                         : {{(N_SRC-1){1'b0}}, src_req[0]};
    assign busy     = (state != ST_IDLE);

    lcd_arb_picker #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_picker (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .rr_mode    (RR_MODE != 0),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // Mux the current owner's signals; the owner index is the RR pointer,
    // which always holds the last winner.
    always_comb begin
        own_req  = 1'b0;
        own_rs   = 1'b0;
        own_rw   = 1'b0;
        own_e    = 1'b0;
        own_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (rr_ptr == PTR_W'(i)) begin
                own_req  = src_req[i];
                own_rs   = src_rs[i];
                own_rw   = src_rw[i];
                own_e    = src_e[i];
                own_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign own_exit = !own_req || (!init_complete_flag && (rr_ptr != '0));

    // Next-state and next-output logic; E defaults low so it only follows
    // the owner while a transaction is genuinely in progress.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        cnt_n    = cnt;
        grant_n  = src_grant;
        data_n   = data;
        rs_n     = RS;
        rw_n     = RW;
        e_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n  = ST_OWN;
                    grant_n  = pick_onehot;
                    rr_ptr_n = pick_idx;
                end
            end
            ST_OWN: begin
                if (own_exit) begin
                    state_n = ST_GUARD;
                    grant_n = '0;
                    cnt_n   = GUARD_LOAD;
                end else begin
                    data_n = own_data;
                    rs_n   = own_rs;
                    rw_n   = own_rw;
                    e_n    = own_e;
                end
            end
            ST_GUARD: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State, pointer, counter and pin registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= PTR_RST;
            cnt       <= '0;
            src_grant <= '0;
            data      <= '0;
            RS        <= 1'b0;
            RW        <= 1'b0;
            E         <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            cnt       <= cnt_n;
            src_grant <= grant_n;
            data      <= data_n;
            RS        <= rs_n;
            RW        <= rw_n;
            E         <= e_n;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: two instances share random stimulus, one in
// fixed-priority mode with a zero guard, one in round-robin mode with a
// guard of 4. A transaction-level reference model predicts each pin update.
module tb_lcd_bus_arbiter;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int EXP_W = N + W + 4;
    localparam int CYCLES = 4000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           init_complete_flag;
    logic [N-1:0]   src_req;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_rs, src_rw, src_e;

    logic [N-1:0] grant_a, grant_b;
    logic [W-1:0] data_a, data_b;
    logic         rs_a, rw_a, e_a, busy_a;
    logic         rs_b, rw_b, e_b, busy_b;

    lcd_bus_arbiter #(.N_SRC(N), .DATA_W(W), .GUARD_CYC(0), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .init_complete_flag(init_complete_flag),
        .src_req(src_req), .src_data(src_data), .src_rs(src_rs),
        .src_rw(src_rw), .src_e(src_e), .src_grant(grant_a), .data(data_a),
        .RS(rs_a), .RW(rw_a), .E(e_a), .busy(busy_a)
    );

    lcd_bus_arbiter #(.N_SRC(N), .DATA_W(W), .GUARD_CYC(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .init_complete_flag(init_complete_flag),
        .src_req(src_req), .src_data(src_data), .src_rs(src_rs),
        .src_rw(src_rw), .src_e(src_e), .src_grant(grant_b), .data(data_b),
        .RS(rs_b), .RW(rw_b), .E(e_b), .busy(busy_b)
    );

    // scoreboard
    logic [EXP_W-1:0] exp_q0[$];
    logic [EXP_W-1:0] exp_q1[$];
    int tests_run = 0;
    int tests_failed = 0;

    // reference model: owner index (-1 = nobody), remaining guard cycles
    int           m_owner[2];
    int           m_guard[2];
    int           m_last[2];
    logic [W-1:0] m_data[2];
    logic         m_rs[2], m_rw[2], m_e[2];

    function automatic int mode_of(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int guard_of(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    task automatic model_step(input int d, output logic [EXP_W-1:0] exp_v);
        int o, w, idx, g1;
        logic [N-1:0] elig, gr;
        g1 = (guard_of(d) < 1) ? 1 : guard_of(d);
        o  = m_owner[d];
        if (rst) begin
            m_owner[d] = -1; m_guard[d] = 0; m_last[d] = N - 1;
            m_data[d] = '0; m_rs[d] = 1'b0; m_rw[d] = 1'b0; m_e[d] = 1'b0;
        end else if (o >= 0) begin
            if (!src_req[o] || (!init_complete_flag && o != 0)) begin
                m_owner[d] = -1;
                m_guard[d] = g1;
                m_e[d]     = 1'b0;
            end else begin
                m_data[d] = src_data[o*W +: W];
                m_rs[d]   = src_rs[o];
                m_rw[d]   = src_rw[o];
                m_e[d]    = src_e[o];
            end
        end else if (m_guard[d] > 0) begin
            m_guard[d] = m_guard[d] - 1;
            m_e[d]     = 1'b0;
        end else begin
            m_e[d] = 1'b0;
            elig = init_complete_flag ? src_req : (src_req & 3'b001);
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mode_of(d) == 1) ? (m_last[d] + 1 + k) % N : k;
                if (w < 0 && elig[idx]) w = idx;
            end
            if (w >= 0) begin
                m_owner[d] = w;
                m_last[d]  = w;
            end
        end
        gr = '0;
        if (m_owner[d] >= 0) gr[m_owner[d]] = 1'b1;
        exp_v = {gr, m_data[d], m_rs[d], m_rw[d], m_e[d],
                 (m_owner[d] >= 0) || (m_guard[d] > 0)};
    endtask

    // driver: new random inputs each negedge, expectation pushed right away
    task automatic drive_cycle(input int cyc);
        logic [EXP_W-1:0] ev;
        rst = (cyc < 2) || (cyc == 2100) || ($urandom_range(0, 999) == 0);
        if (cyc < 40) init_complete_flag = 1'b0;
        else if (init_complete_flag) begin
            if ($urandom_range(0, 79) == 0) init_complete_flag = 1'b0;
        end else begin
            if ($urandom_range(0, 14) == 0) init_complete_flag = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) src_req[i] = ~src_req[i];
            src_data[i*W +: W] = W'($urandom_range(0, 255));
            src_rs[i] = 1'($urandom_range(0, 1));
            src_rw[i] = 1'($urandom_range(0, 1));
            src_e[i]  = 1'($urandom_range(0, 1));
        end
        model_step(0, ev);
        exp_q0.push_back(ev);
        model_step(1, ev);
        exp_q1.push_back(ev);
    endtask

    // monitor: compare each DUT update against the oldest expectation
    initial begin
        logic [EXP_W-1:0] ev, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                ev  = exp_q0.pop_front();
                act = {grant_a, data_a, rs_a, rw_a, e_a, busy_a};
                tests_run++;
                if (act !== ev) begin
                    tests_failed++;
                    $display("FAIL fp_pins t=%0t got grant=%b data=%h rs=%b rw=%b e=%b busy=%b want grant=%b data=%h rs=%b rw=%b e=%b busy=%b",
                             $time, act[EXP_W-1 -: N], act[W+3:4], act[3], act[2], act[1], act[0],
                             ev[EXP_W-1 -: N], ev[W+3:4], ev[3], ev[2], ev[1], ev[0]);
                end
            end
            if (exp_q1.size() > 0) begin
                ev  = exp_q1.pop_front();
                act = {grant_b, data_b, rs_b, rw_b, e_b, busy_b};
                tests_run++;
                if (act !== ev) begin
                    tests_failed++;
                    $display("FAIL rr_pins t=%0t got grant=%b data=%h rs=%b rw=%b e=%b busy=%b want grant=%b data=%h rs=%b rw=%b e=%b busy=%b",
                             $time, act[EXP_W-1 -: N], act[W+3:4], act[3], act[2], act[1], act[0],
                             ev[EXP_W-1 -: N], ev[W+3:4], ev[3], ev[2], ev[1], ev[0]);
                end
            end
        end
    end

    // stimulus sequence and final report
    initial begin
        rst = 1'b1;
        init_complete_flag = 1'b0;
        src_req  = '0;
        src_data = '0;
        src_rs   = '0;
        src_rw   = '0;
        src_e    = '0;
        for (int c = 0; c < CYCLES; c++) begin
            @(negedge clk);
            drive_cycle(c);
        end
        @(posedge clk);
        #2;
        tests_run++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got %0d pending want 0", exp_q0.size() + exp_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Parametrised N-source arbiter for the shared HD44780-style LCD bus (DATA, RS, RW, E). It replaces the fixed 2:1 init/button select with a registered, grant-based arbiter supporting fixed-priority or round-robin selection. Source 0 is the init sequencer and has exclusive access until initialisation completes. The block guarantees E is never asserted during an ownership change, and inserts a programmable E-low guard gap between owners.

Parameters:
N_SRC, 2, number of bus sources (>=2); source 0 is the init sequencer
DATA_W, 8, LCD data bus width
GUARD_CYC, 4, E-low idle cycles between release and next grant (0 treated as 1)
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
init_complete_flag  in  1  high once the init sequence is complete
src_req  in  N_SRC  per-source request; held high for a whole transaction
src_data  in  N_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
src_rs  in  N_SRC  per-source RS
src_rw  in  N_SRC  per-source RW
src_e  in  N_SRC  per-source E
src_grant  out  N_SRC  one-hot grant, registered
data  out  DATA_W  LCD data, registered
RS  out  1  LCD RS, registered
RW  out  1  LCD RW, registered
E  out  1  LCD enable, registered
busy  out  1  high in OWN or GUARD

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: data=0, RS=0, RW=0, E=0, src_grant=0, busy=0, state=IDLE, RR pointer=N_SRC-1, guard counter=0.
- Eligible mask: when init_complete_flag=0, only src_req[0] is eligible. Otherwise all src_req are eligible.
- States: IDLE, OWN, GUARD.
- IDLE: E=0; data, RS and RW hold their last values. If any request is eligible, pick a winner:
  - RR_MODE=0: lowest eligible index.
  - RR_MODE=1: first eligible index after the RR pointer, wrapping modulo N_SRC.
  - Next cycle: src_grant=onehot(winner), state=OWN, RR pointer=winner.
- OWN: each cycle the outputs register the granted source's data/RS/RW/E. Latency from source to pins is exactly 1 cycle. Non-granted sources are ignored entirely, including their E.
- OWN exit conditions: src_req[owner]=0, or (init_complete_flag=0 and owner!=0). On exit, next cycle:
  - E=0; data/RS/RW hold.
  - src_grant=0, state=GUARD, counter=max(GUARD_CYC,1)-1.
  - The owner's src_e in that same cycle is ignored, so E is forced low even if the source drops req with E high.
- GUARD: E=0 and all outputs hold. Counter decrements each cycle. When counter=0, next state=IDLE. The earliest re-grant is therefore max(GUARD_CYC,1)+1 cycles after the exit edge.
- Simultaneous events:
  - Requests arriving during GUARD wait and are arbitrated in IDLE.
  - Owner re-asserting req during GUARD gets no special treatment.
  - Multiple requests in the same IDLE cycle are resolved by mode, with one winner only.
- init_complete_flag deasserting mid-transfer of a non-zero owner aborts it through GUARD. Source 0 is then the only eligible source.
- Reset mid-operation: all registers return to reset values on the next edge; E=0 immediately after that edge.
- busy=1 in OWN and GUARD, 0 in IDLE. src_grant is never multi-hot.

Decomposition:
- Shared package lcd_bus_pkg holds:
  - state encoding constants ST_IDLE, ST_OWN, ST_GUARD;
  - the guard counter width function (clog2 of max(GUARD_CYC,1));
  - default LCD bus width constant LCD_DATA_W=8.
- One sub-module, lcd_arb_picker: combinational, takes the eligible mask, RR pointer and mode, and returns the one-hot winner plus a valid flag. All sequencing stays in lcd_bus_arbiter.

Test Plan:
1. Reset, then src_req=2'b11 with init_complete_flag=0 -> src_grant=2'b01 two cycles after req; E follows src_e[0] with 1-cycle lag; source 1 is never granted.
2. Source 1 owns; drop src_req[1] while src_e[1]=1, GUARD_CYC=4 -> E=0 the next cycle; busy stays high 4 cycles; earliest new grant 5 cycles after the drop edge.
3. N_SRC=3, RR_MODE=0, init done, all requests held (each released after a single transaction) -> grant order 0,0,0… for repeated contention; source 2 is served only when sources 0 and 1 are idle.
4. N_SRC=3, RR_MODE=1, all requests pulsed per transaction -> grant order 0,1,2,0 across four transactions.
5. Source 2 owns with data=8'h41, RS=1; drop init_complete_flag -> next cycle E=0, src_grant=0, data holds 8'h41; after the guard gap, source 0 is granted.
6. Assert rst during OWN with E=1 -> next cycle E=0, data=0, src_grant=0, busy=0; GUARD_CYC=0 then gives a 1-cycle guard on the next release.
